// File: rtl/ppu_a12_filter_if.sv
// ============================================================================
// Module   : ppu_a12_filter_if
// Brief    : Signal bundle between the PPU/CPU pins and the A12 edge filter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ppu_a12_filter_if;
  logic        ppu_a12;
  logic        m2;
  logic        ss_act;
  logic        a12_clean;
  logic        a12_rise;
  logic        a12_rise_raw;
  logic [15:0] rise_cnt;

  modport master (
    output ppu_a12, m2, ss_act,
    input  a12_clean, a12_rise, a12_rise_raw, rise_cnt
  );

  modport slave (
    input  ppu_a12, m2, ss_act,
    output a12_clean, a12_rise, a12_rise_raw, rise_cnt
  );
endinterface

`default_nettype wire

// File: rtl/ppu_a12_filter.sv
// ============================================================================
// Module   : ppu_a12_filter
// Brief    : Synchronises/deglitches PPU A12 and emits a qualified 1-clk rise
//            strobe for the scanline IRQ counter. Optional A12_RISE_CNT_EN
//            enables the 16-bit qualified-rise counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ppu_a12_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CLKS = 2,
  parameter int M2_LOW_MIN  = 3
) (
  input  logic            clk,
  input  logic            map_rst,
  ppu_a12_filter_if.slave bus
);

  localparam logic [3:0] c_gctr_last = 4'(GLITCH_CLKS - 1);
  localparam logic [3:0] c_low_min   = 4'(M2_LOW_MIN);
  localparam logic [3:0] c_low_max   = 4'hF;

  logic [SYNC_STAGES-1:0] r_a12_sync;
  logic [SYNC_STAGES-1:0] r_m2_sync;
  logic                   r_m2_prev;
  logic                   r_a12_clean;
  logic [3:0]             r_gctr;
  logic [3:0]             r_low_cnt;
  logic                   r_rise;
  logic                   r_rise_raw;

  logic                   w_a12_s;
  logic                   w_m2_s;
  logic                   w_m2_fall;
  logic                   w_rise;
  logic                   w_raw_next;
  logic                   w_qual;

  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      r_a12_sync <= '0;
      r_m2_sync  <= '0;
      r_m2_prev  <= 1'b0;
    end else begin
      r_a12_sync <= {r_a12_sync[SYNC_STAGES-2:0], bus.ppu_a12};
      r_m2_sync  <= {r_m2_sync[SYNC_STAGES-2:0], bus.m2};
      r_m2_prev  <= w_m2_s;
    end
  end

  // w_rise is the next-state compare: a12_clean goes 0->1 on this edge.
  always_comb begin
    w_a12_s    = r_a12_sync[SYNC_STAGES-1];
    w_m2_s     = r_m2_sync[SYNC_STAGES-1];
    w_m2_fall  = r_m2_prev & ~w_m2_s;
    w_rise     = w_a12_s & ~r_a12_clean & (r_gctr == c_gctr_last);
    w_raw_next = w_rise & ~bus.ss_act;
    w_qual     = w_raw_next & (r_low_cnt >= c_low_min);
  end

  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      r_a12_clean <= 1'b0;
      r_gctr      <= 4'd0;
    end else if (w_a12_s == r_a12_clean) begin
      r_gctr <= 4'd0;
    end else if (r_gctr == c_gctr_last) begin
      r_a12_clean <= w_a12_s;
      r_gctr      <= 4'd0;
    end else begin
      r_gctr <= r_gctr + 4'd1;
    end
  end

  // A fall landing on the rising update is compared pre-increment and then
  // discarded when a12_clean clears the count.
  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      r_low_cnt <= 4'd0;
    end else if (r_a12_clean) begin
      r_low_cnt <= 4'd0;
    end else if (w_m2_fall && !bus.ss_act && (r_low_cnt != c_low_max)) begin
      r_low_cnt <= r_low_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      r_rise     <= 1'b0;
      r_rise_raw <= 1'b0;
    end else begin
      r_rise     <= w_qual;
      r_rise_raw <= w_raw_next;
    end
  end

  assign bus.a12_clean    = r_a12_clean;
  assign bus.a12_rise     = r_rise;
  assign bus.a12_rise_raw = r_rise_raw;

`ifdef A12_RISE_CNT_EN
  logic [15:0] r_rise_cnt;

  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      r_rise_cnt <= 16'h0000;
    end else if (w_qual) begin
      r_rise_cnt <= r_rise_cnt + 16'h0001;
    end
  end

  assign bus.rise_cnt = r_rise_cnt;
`else
  assign bus.rise_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ppu_a12_filter.sv
// ============================================================================
// Module   : tb_ppu_a12_filter
// Brief    : Directed self-checking bench for ppu_a12_filter (default params).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ppu_a12_filter;

`ifdef A12_RISE_CNT_EN
  localparam bit c_cnt_en = 1'b1;
`else
  localparam bit c_cnt_en = 1'b0;
`endif

  logic        clk;
  logic        map_rst;
  int          n_cmp;
  int          n_bad;
  logic [15:0] exp_cnt;

  ppu_a12_filter_if bus ();

  ppu_a12_filter dut (
    .clk     (clk),
    .map_rst (map_rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m2_pulse();
    bus.m2 = 1'b1;
    tick();
    tick();
    bus.m2 = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_rise(input int n_falls);
    bus.ppu_a12 = 1'b0;
    repeat (6) tick();
    repeat (n_falls) m2_pulse();
    tick();
    bus.ppu_a12 = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.a12_clean, bus.a12_rise, bus.a12_rise_raw} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 000",
               {bus.a12_clean, bus.a12_rise, bus.a12_rise_raw});
    end
    n_cmp++;
    if (bus.rise_cnt !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_rise_cnt: got %h expected 0000", bus.rise_cnt);
    end
    map_rst = 1'b0;
    tick();
    bus.ppu_a12 = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (bus.a12_clean !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_clean: got %b expected 1", bus.a12_clean);
    end
    // Asynchronous assertion mid-cycle, a12 held high.
    map_rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.a12_clean, bus.a12_rise, bus.a12_rise_raw} !== 3'b000) begin
      n_bad++;
      $display("FAIL async_reset: got %b expected 000",
               {bus.a12_clean, bus.a12_rise, bus.a12_rise_raw});
    end
    tick();
    tick();
    map_rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (bus.a12_clean !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_early: got %b expected 0", bus.a12_clean);
    end
    tick();
    n_cmp++;
    if ({bus.a12_clean, bus.a12_rise_raw, bus.a12_rise} !== 3'b110) begin
      n_bad++;
      $display("FAIL post_reset_rise: clean/raw/rise got %b expected 110",
               {bus.a12_clean, bus.a12_rise_raw, bus.a12_rise});
    end
    tick();
  endtask

  task automatic test_qualified_rise();
    bus.ppu_a12 = 1'b0;
    repeat (6) tick();
    repeat (4) m2_pulse();
    tick();
    bus.ppu_a12 = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({bus.a12_clean, bus.a12_rise_raw, bus.a12_rise} !== 3'b000) begin
      n_bad++;
      $display("FAIL qual_early: clean/raw/rise got %b expected 000",
               {bus.a12_clean, bus.a12_rise_raw, bus.a12_rise});
    end
    tick();
    exp_cnt = exp_cnt + 16'h0001;
    n_cmp++;
    if ({bus.a12_clean, bus.a12_rise_raw, bus.a12_rise} !== 3'b111) begin
      n_bad++;
      $display("FAIL qual_edge: clean/raw/rise got %b expected 111",
               {bus.a12_clean, bus.a12_rise_raw, bus.a12_rise});
    end
    tick();
    n_cmp++;
    if ({bus.a12_clean, bus.a12_rise_raw, bus.a12_rise} !== 3'b100) begin
      n_bad++;
      $display("FAIL qual_one_clk: clean/raw/rise got %b expected 100",
               {bus.a12_clean, bus.a12_rise_raw, bus.a12_rise});
    end
    repeat (5) tick();
    n_cmp++;
    if ({bus.a12_clean, bus.a12_rise_raw, bus.a12_rise} !== 3'b100) begin
      n_bad++;
      $display("FAIL qual_hold: clean/raw/rise got %b expected 100",
               {bus.a12_clean, bus.a12_rise_raw, bus.a12_rise});
    end
    n_cmp++;
    if (bus.rise_cnt !== (c_cnt_en ? exp_cnt : 16'h0000)) begin
      n_bad++;
      $display("FAIL qual_rise_cnt: got %h expected %h", bus.rise_cnt,
               c_cnt_en ? exp_cnt : 16'h0000);
    end
  endtask

  task automatic test_glitch();
    bus.ppu_a12 = 1'b0;
    repeat (6) tick();
    repeat (4) m2_pulse();
    tick();
    bus.ppu_a12 = 1'b1;
    tick();
    bus.ppu_a12 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({bus.a12_clean, bus.a12_rise_raw, bus.a12_rise} !== 3'b000) begin
        n_bad++;
        $display("FAIL glitch_1clk[%0d]: got %b expected 000", i,
                 {bus.a12_clean, bus.a12_rise_raw, bus.a12_rise});
      end
    end
    bus.ppu_a12 = 1'b1;
    tick();
    bus.ppu_a12 = 1'b0;
    tick();
    bus.ppu_a12 = 1'b1;
    tick();
    bus.ppu_a12 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({bus.a12_clean, bus.a12_rise_raw, bus.a12_rise} !== 3'b000) begin
        n_bad++;
        $display("FAIL glitch_broken[%0d]: got %b expected 000", i,
                 {bus.a12_clean, bus.a12_rise_raw, bus.a12_rise});
      end
    end
  endtask

  task automatic test_unqualified();
    // Re-arm a12 high so low_cnt starts from zero.
    bus.ppu_a12 = 1'b1;
    repeat (6) tick();
    bus.ppu_a12 = 1'b0;
    repeat (6) tick();
    repeat (2) m2_pulse();
    tick();
    bus.ppu_a12 = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if ({bus.a12_clean, bus.a12_rise_raw, bus.a12_rise} !== 3'b110) begin
      n_bad++;
      $display("FAIL unqual_2falls: clean/raw/rise got %b expected 110",
               {bus.a12_clean, bus.a12_rise_raw, bus.a12_rise});
    end
    repeat (2) tick();
    bus.ppu_a12 = 1'b0;
    repeat (6) tick();
    repeat (2) m2_pulse();
    tick();
    // Third fall lands on the same edge as the a12_clean update.
    bus.m2 = 1'b1;
    tick();
    bus.ppu_a12 = 1'b1;
    tick();
    bus.m2 = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({bus.a12_clean, bus.a12_rise_raw, bus.a12_rise} !== 3'b110) begin
      n_bad++;
      $display("FAIL unqual_coincident: clean/raw/rise got %b expected 110",
               {bus.a12_clean, bus.a12_rise_raw, bus.a12_rise});
    end
    repeat (2) tick();
  endtask

  task automatic test_ss_act();
    bus.ppu_a12 = 1'b0;
    repeat (6) tick();
    repeat (3) m2_pulse();
    tick();
    bus.ss_act  = 1'b1;
    bus.ppu_a12 = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({bus.a12_clean, bus.a12_rise_raw, bus.a12_rise} !== 3'b000) begin
      n_bad++;
      $display("FAIL ss_early: clean/raw/rise got %b expected 000",
               {bus.a12_clean, bus.a12_rise_raw, bus.a12_rise});
    end
    tick();
    n_cmp++;
    if ({bus.a12_clean, bus.a12_rise_raw, bus.a12_rise} !== 3'b100) begin
      n_bad++;
      $display("FAIL ss_block: clean/raw/rise got %b expected 100",
               {bus.a12_clean, bus.a12_rise_raw, bus.a12_rise});
    end
    tick();
    bus.ss_act = 1'b0;
    tick();
    bus.ppu_a12 = 1'b0;
    repeat (6) tick();
    m2_pulse();
    tick();
    bus.ss_act = 1'b1;
    repeat (5) m2_pulse();
    tick();
    bus.ss_act = 1'b0;
    // Frozen at 1, one more fall gives 2: still short of qualifying.
    m2_pulse();
    tick();
    bus.ppu_a12 = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if ({bus.a12_clean, bus.a12_rise_raw, bus.a12_rise} !== 3'b110) begin
      n_bad++;
      $display("FAIL ss_freeze: clean/raw/rise got %b expected 110",
               {bus.a12_clean, bus.a12_rise_raw, bus.a12_rise});
    end
    repeat (2) tick();
  endtask

  task automatic test_rise_cnt();
    map_rst = 1'b1;
    tick();
    map_rst = 1'b0;
    exp_cnt = 16'h0000;
    tick();
    n_cmp++;
    if (bus.rise_cnt !== 16'h0000) begin
      n_bad++;
      $display("FAIL cnt_cleared: got %h expected 0000", bus.rise_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      do_rise(3);
      exp_cnt = exp_cnt + 16'h0001;
    end
    do_rise(1);
    n_cmp++;
    if (bus.rise_cnt !== (c_cnt_en ? exp_cnt : 16'h0000)) begin
      n_bad++;
      $display("FAIL cnt_three: got %h expected %h", bus.rise_cnt,
               c_cnt_en ? exp_cnt : 16'h0000);
    end
`ifdef A12_RISE_CNT_EN
    force dut.r_rise_cnt = 16'hFFFF;
    #1;
    release dut.r_rise_cnt;
    exp_cnt = 16'hFFFF;
    n_cmp++;
    if (bus.rise_cnt !== exp_cnt) begin
      n_bad++;
      $display("FAIL cnt_forced: got %h expected %h", bus.rise_cnt, exp_cnt);
    end
`endif
    do_rise(3);
    exp_cnt = exp_cnt + 16'h0001;
    n_cmp++;
    if (bus.rise_cnt !== (c_cnt_en ? exp_cnt : 16'h0000)) begin
      n_bad++;
      $display("FAIL cnt_wrap: got %h expected %h", bus.rise_cnt,
               c_cnt_en ? exp_cnt : 16'h0000);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    exp_cnt     = 16'h0000;
    map_rst     = 1'b1;
    bus.ppu_a12 = 1'b0;
    bus.m2      = 1'b0;
    bus.ss_act  = 1'b0;
    tick();
    tick();
    test_reset();
    test_qualified_rise();
    test_glitch();
    test_unqualified();
    test_ss_act();
    test_rise_cnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
